// File: rtl/logic_unit_pkg.sv
// Shared op codes and FSM state encodings for the bitwise logic unit and the ALU decoder.
package logic_unit_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_XNOR = 3'd3;
   localparam logic [2:0] OP_NAND = 3'd4;
   localparam logic [2:0] OP_NOR  = 3'd5;
   localparam logic [2:0] OP_NOTA = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise op on one SLICE-wide slice of the operands.
module logic_slice
   import logic_unit_pkg::*;
#(
   parameter int SLICE = 4
) (
   input  logic [2:0]       op,
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   output logic [SLICE-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_NOTA: y = ~a;
         OP_PASS: y = a;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic_slice_unit.sv
// Multi-cycle bitwise logic unit: one SLICE-wide slice per cycle, LSB first, with
// valid/ready handshakes on both sides and zero/parity flags at completion.
//
//  state   | meaning
//  IDLE    | in_ready high, waiting for a request
//  BUSY    | writing one result slice per cycle
//  DONE    | out_valid high, result held until out_ready
module logic_slice_unit
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             parity,
   output logic             busy
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   if (WIDTH % SLICE != 0) begin : g_bad_cfg
      $error("logic_slice_unit: WIDTH must be a multiple of SLICE");
   end

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
   logic [2:0]       op_q;
   logic             zero_q, parity_q, out_valid_q, busy_q, in_ready_q;

   logic [SLICE-1:0] a_sl, b_sl, y_sl;
   logic             last_slice;

   // Counter-indexed operand mux feeding the single slice evaluator.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (cnt_q == CW'(i)) begin
            a_sl = a_q[i*SLICE +: SLICE];
            b_sl = b_q[i*SLICE +: SLICE];
         end
      end
   end

   logic_slice #(.SLICE(SLICE)) u_slice (
      .op (op_q),
      .a  (a_sl),
      .b  (b_sl),
      .y  (y_sl)
   );

   always_comb begin
      res_d = res_q;
      for (int i = 0; i < NSLICE; i++) begin
         if (cnt_q == CW'(i)) res_d[i*SLICE +: SLICE] = y_sl;
      end
   end

   assign last_slice = (cnt_q == CW'(NSLICE - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         res_q       <= '0;
         zero_q      <= 1'b0;
         parity_q    <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  b_q        <= b;
                  op_q       <= op;
                  res_q      <= '0;
                  cnt_q      <= '0;
                  state_q    <= ST_BUSY;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b0;
               end
            end
            ST_BUSY: begin
               res_q <= res_d;
               if (last_slice) begin
                  // Flags come from the full word including the slice written this cycle.
                  zero_q      <= (res_d == '0);
                  parity_q    <= ^res_d;
                  state_q     <= ST_DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = res_q;
   assign zero      = zero_q;
   assign parity    = parity_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_logic_slice_unit.sv
// Directed and random checks of logic_slice_unit at SLICE=4, 16 and 1 against a word-level model.
module tb_logic_slice_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  iv;
   logic [2:0]  ordy;
   logic [2:0]  op;
   logic [15:0] a, b;

   logic        ir  [3];
   logic        ov  [3];
   logic        zf  [3];
   logic        pf  [3];
   logic        bz  [3];
   logic [15:0] res [3];

   int n_vec = 0;
   int n_err = 0;
   int ns [3] = '{4, 1, 16};

   always #5 clk = ~clk;

   logic_slice_unit #(.WIDTH(16), .SLICE(4)) dut (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .op(op), .a(a), .b(b),
      .out_valid(ov[0]), .out_ready(ordy[0]), .result(res[0]), .zero(zf[0]),
      .parity(pf[0]), .busy(bz[0])
   );

   logic_slice_unit #(.WIDTH(16), .SLICE(16)) dut_w (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .op(op), .a(a), .b(b),
      .out_valid(ov[1]), .out_ready(ordy[1]), .result(res[1]), .zero(zf[1]),
      .parity(pf[1]), .busy(bz[1])
   );

   logic_slice_unit #(.WIDTH(16), .SLICE(1)) dut_n (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .op(op), .a(a), .b(b),
      .out_valid(ov[2]), .out_ready(ordy[2]), .result(res[2]), .zero(zf[2]),
      .parity(pf[2]), .busy(bz[2])
   );

   function automatic logic [15:0] ref_op(logic [2:0] o, logic [15:0] x, logic [15:0] y);
      case (o)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return x ^ y;
         3'd3:    return ~(x ^ y);
         3'd4:    return ~(x & y);
         3'd5:    return ~(x | y);
         3'd6:    return ~x;
         default: return x;
      endcase
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one request on DUT idx, scramble inputs during BUSY, and check latency/result/flags.
   task automatic run(int idx, logic [2:0] o, logic [15:0] av, logic [15:0] bv);
      logic [15:0] exp;
      int          lat;
      exp = ref_op(o, av, bv);
      check($sformatf("in_ready_idle[%0d]", idx), {31'd0, ir[idx]}, 32'd1);
      op = o; a = av; b = bv; iv[idx] = 1'b1;
      tick();
      iv[idx] = 1'b0;
      op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
      check($sformatf("busy[%0d]", idx), {31'd0, bz[idx]}, 32'd1);
      lat = 0;
      while (ov[idx] !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check($sformatf("latency[%0d]", idx), lat, ns[idx]);
      check($sformatf("result[%0d] op%0d", idx, o), {16'd0, res[idx]}, {16'd0, exp});
      check($sformatf("zero[%0d]", idx), {31'd0, zf[idx]}, {31'd0, exp == 16'd0});
      check($sformatf("parity[%0d]", idx), {31'd0, pf[idx]}, {31'd0, ^exp});
      check($sformatf("in_ready_done[%0d]", idx), {31'd0, ir[idx]}, 32'd0);
   endtask

   task automatic release_out(int idx, logic [15:0] held);
      ordy[idx] = 1'b1;
      tick();
      ordy[idx] = 1'b0;
      check($sformatf("out_valid_drop[%0d]", idx), {31'd0, ov[idx]}, 32'd0);
      check($sformatf("in_ready_rise[%0d]", idx), {31'd0, ir[idx]}, 32'd1);
      check($sformatf("result_kept[%0d]", idx), {16'd0, res[idx]}, {16'd0, held});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  ro;
      logic [15:0] ra, rb;
      rst = 1'b1; iv = '0; ordy = '0; op = '0; a = '0; b = '0;
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_in_ready[%0d]", i), {31'd0, ir[i]}, 32'd1);
         check($sformatf("rst_out_valid[%0d]", i), {31'd0, ov[i]}, 32'd0);
         check($sformatf("rst_result[%0d]", i), {16'd0, res[i]}, 32'd0);
         check($sformatf("rst_flags[%0d]", i), {29'd0, zf[i], pf[i], bz[i]}, 32'd0);
      end
      rst = 1'b0;
      tick();
      check("in_ready_after_rst", {31'd0, ir[0]}, 32'd1);

      // Directed cases on the SLICE=4 unit.
      run(0, 3'd2, 16'h1559, 16'h1551);
      check("xor_value", {16'd0, res[0]}, 32'h0008);
      release_out(0, 16'h0008);
      run(0, 3'd4, 16'hFFFF, 16'hFFFF);
      check("nand_zero", {31'd0, zf[0]}, 32'd1);
      release_out(0, 16'h0000);
      run(0, 3'd5, 16'h0000, 16'h0000);
      release_out(0, 16'hFFFF);
      run(0, 3'd6, 16'h00FF, 16'h1234);
      check("nota_value", {16'd0, res[0]}, 32'hFF00);
      release_out(0, 16'hFF00);
      run(0, 3'd7, 16'h8001, 16'h0000);
      release_out(0, 16'h8001);

      // Backpressure: hold DONE for 5 cycles while pulsing in_valid.
      run(0, 3'd0, 16'hA5C3, 16'h0FF0);
      for (int k = 0; k < 5; k++) begin
         iv[0] = k[0] ? 1'b0 : 1'b1;
         a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
         tick();
         check("bp_result", {16'd0, res[0]}, 32'h05C0);
         check("bp_out_valid", {31'd0, ov[0]}, 32'd1);
         check("bp_in_ready", {31'd0, ir[0]}, 32'd0);
         check("bp_flags", {30'd0, zf[0], pf[0]}, {30'd0, 1'b0, ^16'h05C0});
      end
      iv[0] = 1'b0;
      release_out(0, 16'h05C0);

      // Abort mid-operation with reset, then a clean request.
      op = 3'd1; a = 16'h1234; b = 16'h4321; iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("abort_out_valid", {31'd0, ov[0]}, 32'd0);
      check("abort_result", {16'd0, res[0]}, 32'd0);
      check("abort_busy", {31'd0, bz[0]}, 32'd0);
      rst = 1'b0;
      tick();
      check("abort_in_ready", {31'd0, ir[0]}, 32'd1);
      check("abort_no_output", {31'd0, ov[0]}, 32'd0);
      run(0, 3'd3, 16'h1234, 16'h4321);
      release_out(0, ref_op(3'd3, 16'h1234, 16'h4321));

      // Random ops on all three slice widths.
      for (int idx = 0; idx < 3; idx++) begin
         for (int n = 0; n < 20; n++) begin
            ro = 3'($urandom_range(7));
            ra = (n == 0) ? 16'h0000 : 16'($urandom);
            rb = 16'($urandom);
            run(idx, ro, ra, rb);
            release_out(idx, ref_op(ro, ra, rb));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
